// File: rtl/cnn_pkg.sv
// Shared CNN layer constants and small elaboration helpers.
package cnn_pkg;

    localparam int unsigned DATA_W    = 13;
    localparam int unsigned IMG_W     = 26;
    localparam int unsigned IMG_H     = 26;
    localparam int unsigned CONV_K    = 3;
    localparam int unsigned N_FILTERS = 8;

    // Address width for a memory of the given depth; a 1-deep memory still gets 1 bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one row of horizontal pair maxima: one write port, one async read port.
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W / 2,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [addr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [addr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 max pooling over a raster-order feature map, one pooled result per completed window.
module maxpool_2x2 #(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W,
    parameter int unsigned IMG_W  = cnn_pkg::IMG_W,
    parameter int unsigned IMG_H  = cnn_pkg::IMG_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);
    import cnn_pkg::*;

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned BUF_D = IMG_W / 2;
    localparam int unsigned AW    = addr_w(BUF_D);

    if (IMG_W < 2 || (IMG_W % 2) != 0 || IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_geometry
        $error("maxpool_2x2: IMG_W and IMG_H must be even and at least 2");
    end

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] buf_rdata;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] win_max;
    logic [AW-1:0]     buf_addr;
    logic              buf_we;
    logic              col_last;
    logic              row_last;

    always_comb begin
        col_last = (col == COL_W'(IMG_W - 1));
        row_last = (row == ROW_W'(IMG_H - 1));
        pair_max = (hold > in_data) ? hold : in_data;
        win_max  = (pair_max > buf_rdata) ? pair_max : buf_rdata;
        buf_addr = AW'(col >> 1);
        // Only even rows write; odd rows read the same entry back on the matching column.
        buf_we   = in_valid & ~rst & col[0] & ~row[0];
    end

    pool_line_buf #(
        .DEPTH (BUF_D),
        .WIDTH (DATA_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_addr),
        .wdata (pair_max),
        .raddr (buf_addr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (!col[0]) begin
                    hold <= in_data;
                end
                if (col[0] && row[0]) begin
                    out_data   <= win_max;
                    out_valid  <= 1'b1;
                    frame_done <= col_last && row_last;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2 on a 4x4 map: directed frames plus randomized data and gaps.
module tb_maxpool_2x2;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          frame_done;

    always #5 clk = ~clk;

    maxpool_2x2 #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          done;
        int unsigned   cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] seen[$];
    int            done_cnt = 0;
    int            checks   = 0;
    int            failures = 0;
    int unsigned   cyc      = 0;
    logic          rst_q    = 1'b0;
    logic          mon_en   = 1'b0;
    logic [DW-1:0] last_out = '0;

    // Reference model state: pixels of the current frame by raster index.
    logic [DW-1:0] fr [W*H];
    int unsigned   n = 0;
    logic [DW-1:0] frm [W*H];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return DW'(m);
    endfunction

    task automatic model_accept(input logic [DW-1:0] d);
        int unsigned r, c;
        exp_t e;
        fr[n] = d;
        r = n / W;
        c = n % W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.data = max4(fr[(r-1)*W + c-1], fr[(r-1)*W + c], fr[r*W + c-1], d);
            e.done = (n == W*H - 1);
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        n = (n + 1) % (W*H);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_data  = d;
        if (r) n = 0;
        else if (v) model_accept(d);
    endtask

    task automatic feed(input int count, input int duty);
        for (int i = 0; i < count; i++) begin
            while ($urandom_range(99) >= duty) drive(1'b0, DW'($urandom), 1'b0);
            drive(1'b1, frm[i], 1'b0);
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, '0, 1'b0);
    endtask

    task automatic expect_seen(input string name, input int unsigned exp_vals[$]);
        check({name, "_count"}, seen.size(), exp_vals.size());
        for (int i = 0; i < exp_vals.size() && i < seen.size(); i++)
            check(name, seen[i], exp_vals[i]);
        seen.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) last_out = '0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got data %0d with no pending window (t=%0t)", out_data, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("frame_done", frame_done, e.done);
                    check("latency_cycle", cyc, e.cyc);
                end
                seen.push_back(out_data);
                if (frame_done) done_cnt++;
                last_out = out_data;
            end else begin
                check("out_data_hold", out_data, last_out);
                check("frame_done_idle", frame_done, 1'b0);
            end
        end
    end

    initial begin
        int unsigned q[$];
        int d0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_col", dut.col, 0);
        check("rst_row", dut.row, 0);
        mon_en = 1'b1;
        idle(1);

        // Continuous ramp 0..15
        for (int i = 0; i < W*H; i++) frm[i] = DW'(i);
        d0 = done_cnt;
        feed(W*H, 100);
        idle(3);
        q = '{5, 7, 13, 15};
        expect_seen("ramp", q);
        check("ramp_frame_done_cnt", done_cnt - d0, 1);

        // Full-scale value in one corner, then an all-zero frame
        for (int i = 0; i < W*H; i++) frm[i] = '0;
        frm[0] = 13'd8191;
        feed(W*H, 100);
        frm[0] = '0;
        feed(W*H, 100);
        idle(3);
        q = '{8191, 0, 0, 0, 0, 0, 0, 0};
        expect_seen("unsigned", q);

        // Same ramp with ~30% valid duty
        for (int i = 0; i < W*H; i++) frm[i] = DW'(i);
        feed(W*H, 30);
        idle(3);
        q = '{5, 7, 13, 15};
        expect_seen("gaps", q);

        // Back-to-back frames, ascending then descending
        d0 = done_cnt;
        feed(W*H, 100);
        for (int i = 0; i < W*H; i++) frm[i] = DW'(W*H - 1 - i);
        feed(W*H, 100);
        idle(3);
        q = '{5, 7, 13, 15, 15, 13, 7, 5};
        expect_seen("b2b", q);
        check("b2b_frame_done_cnt", done_cnt - d0, 2);

        // Partial frame of 6 pixels, reset, then a full frame
        for (int i = 0; i < W*H; i++) frm[i] = DW'(i);
        feed(6, 100);
        idle(3);
        seen.delete();
        drive(1'b0, '0, 1'b1);
        idle(1);
        feed(W*H, 100);
        idle(3);
        q = '{5, 7, 13, 15};
        expect_seen("mid_reset", q);

        // Reset coincident with a valid pixel drops that pixel
        drive(1'b1, 13'd4000, 1'b1);
        drive(1'b0, '0, 1'b0);
        check("rst_valid_col", dut.col, 0);
        check("rst_valid_row", dut.row, 0);
        feed(W*H, 100);
        idle(3);
        q = '{5, 7, 13, 15};
        expect_seen("rst_valid", q);

        // Randomized frames with random data and duty
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < W*H; i++) frm[i] = DW'($urandom);
            feed(W*H, int'($urandom_range(100, 25)));
        end
        seen.delete();

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check("drain_pending", sb.size(), 0);
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
